prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Instruction prefetch queue directly upstream of the decoder.
- Fetches 16-bit words from the memory bus into a circular buffer, one read outstanding at a time.
- Frames each whole instruction (1 or 2 words) and hands it to the decoder as a 32-bit `cmd` over the `rqi_p`/`aki_n` handshake.
- Flushed and redirected by the execution unit on a taken branch.

Parameters:
- DEPTH, 4: buffer depth in 16-bit words; power of two, minimum 2.
- RESET_PC, 16'h0000: word address of the first fetch after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rq_p  out  1  memory read request; held high until `mem_ack`.
- mem_adr  out  16  word address; stable while `mem_rq_p` is high.
- mem_ack  in  1  one-cycle read completion; `mem_din` is valid in that cycle.
- mem_din  in  16  read data; bits 15:8 are the first byte.
- rqi_p  in  1  decoder ready for the next instruction.
- aki_n  out  1  one-cycle pulse, asserted = 1; `cmd` is valid in that cycle.
- cmd  out  32  framed instruction; word0 in 31:16, word1 in 15:0.
- flush_p  in  1  discard the queue and refetch from `flush_adr`.
- flush_adr  in  16  new fetch word address.

Behaviour:
- Reset values: `mem_rq_p`=0, `mem_adr`=RESET_PC, `aki_n`=0, `cmd`=0.
- Reset internals: count=0, head/tail=0, fetch_pc=RESET_PC, drop=0.
- Reset mid-transfer abandons the transfer; a late `mem_ack` after reset is ignored while `mem_rq_p`=0.
- Buffer:
  - circular, DEPTH entries; head/tail wrap modulo DEPTH; count 0..DEPTH.
- Fetch FSM states:
  - IDLE: if count + 1 <= DEPTH and no flush, raise `mem_rq_p` with `mem_adr`=fetch_pc, go to WAIT.
  - WAIT: on `mem_ack`:
    - if drop=0: write `mem_din` at tail, count += 1, fetch_pc += 1 (16'hFFFF wraps to 0);
    - if drop=1: discard the data and clear drop;
    - drop `mem_rq_p`, return to IDLE.
  - Request rate: at most one request per two cycles.
  - Full buffer: no request issued.
- Length decode on word0 = head entry:
  - L=1 when word0[15:14]==2'b11 (opcode classes C–F);
  - L=2 otherwise.
  - valid = count >= L.
- Delivery (output register):
  - Load condition at an edge: `rqi_p`=1, valid=1, `aki_n`=0, no flush.
  - On load: `cmd`={word0, L==2 ? word1 : 16'h0000}; pop L words; `aki_n`=1 for the next cycle only.
  - `aki_n` is never high two consecutive cycles; the gap cycle absorbs the decoder lowering `rqi_p`.
  - `cmd` holds its value after the pulse until the next load.
  - Simultaneous pop and `mem_ack` in one cycle: count += 1 - L.
- Flush (`flush_p`=1 at an edge):
  - count=0, head=tail=0, fetch_pc=`flush_adr`, `aki_n` forced 0 next cycle.
  - If in WAIT: drop=1; the in-flight read completes normally and its data is discarded.
  - Flush takes priority over `mem_ack` write and over delivery in the same cycle.
  - Repeated flushes: the last `flush_adr` wins.
- Latency, no bypass:
  - `mem_ack` at edge E writes the word;
  - earliest load at edge E+1;
  - `aki_n` high in the cycle after E+1.

Optional Feature:
- PQ_BYPASS_EN defined:
  - Condition at edge E: `mem_ack`, drop=0, count=0, `rqi_p`=1, `aki_n`=0, no flush, and `mem_din`[15:14]==2'b11.
  - Action: load `cmd`={`mem_din`,16'h0000} directly without a buffer write; fetch_pc still increments.
  - Result: `aki_n` high in the cycle after E, one cycle earlier than without bypass.
- Undefined: all data goes through the buffer; latency as stated under Behaviour.

Decomposition:
- Package pq_pkg:
  - WORD_W=16, CMD_W=32, default DEPTH/RESET_PC;
  - fetch FSM state encoding;
  - instr_len function (word0 -> 1 or 2).
- One sub-module pq_fifo:
  - circular buffer with single-word push and 1-or-2-word pop;
  - exposes word0, word1, count;
  - synchronous clear.

Test Plan:
- Reset, 1-cycle `mem_ack`, memory[0]=16'h1234, [1]=16'h5678, `rqi_p`=1 -> `mem_adr` 0 then 1; one `aki_n` pulse with `cmd`=32'h12345678; no pulse before both words are present.
- memory[0]=16'hC123 -> `cmd`=32'hC1230000 with L=1; next instruction framed from word 1.
- `rqi_p`=0 for 20 cycles -> exactly DEPTH reads issued, `mem_rq_p` stays 0 when full; raising `rqi_p` yields pulses separated by at least one idle cycle.
- `flush_p` with `flush_adr`=16'h0040 during WAIT with 3 buffered words -> in-flight data discarded, count=0, next `mem_adr`=16'h0040, no stale `cmd` delivered.
- 2-word instruction spanning the buffer wrap (head at DEPTH-1) -> correct `cmd`; pointer wrap verified; `flush_adr`=16'hFFFF then fetch wraps to 16'h0000.
- PQ_BYPASS_EN, empty queue, `mem_din`=16'hD001 -> `aki_n` in the cycle after `mem_ack`; without the macro, one cycle later.

Source files
------------

// File: rtl/pq_pkg.sv
// pq_pkg: shared constants, fetch FSM encoding and instruction length decode
// for the prefetch queue (prefetch_queue, pq_fifo).
package pq_pkg;

    localparam int              WORD_W       = 16;
    localparam int              CMD_W        = 32;
    localparam int              DEF_DEPTH    = 4;
    localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    // Opcode classes C-F (top two bits set) are single-word instructions.
    function automatic logic [1:0] instr_len(input logic [WORD_W-1:0] word0);
        return (word0[15:14] == 2'b11) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// pq_fifo: circular word buffer for the prefetch queue.
// Single-word push at the tail, one- or two-word pop at the head.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous clear (pointers and count to zero)
//   push, din     write din at tail
//   pop, pop_two  remove 1 word (pop_two=0) or 2 words (pop_two=1) from head
//   word0, word1  entries at head and head+1
//   count         number of valid words, 0..DEPTH
module pq_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WORD_W-1:0]      din,
    input  logic                   pop,
    input  logic                   pop_two,
    output logic [WORD_W-1:0]      word0,
    output logic [WORD_W-1:0]      word1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_p1;
    logic [1:0]        pop_n;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    assign head_p1 = head + PTR_W'(1);
    assign word0   = mem[head];
    assign word1   = mem[head_p1];
    assign pop_n   = pop ? (pop_two ? 2'd2 : 2'd1) : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            head  <= head + PTR_W'(pop_n);
            count <= count + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= din;
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch queue in front of the decoder.
// Fetches 16-bit words (one read outstanding), buffers them in pq_fifo,
// frames 1- or 2-word instructions into a 32-bit cmd and hands them over
// with a one-cycle aki_n pulse. flush_p discards everything and refetches.
// Optional: define PQ_BYPASS_EN to deliver a single-word instruction straight
// from mem_din when the queue is empty (one cycle less latency).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_rq_p, mem_adr    read request (held until mem_ack), word address
//   mem_ack, mem_din     one-cycle read completion and its data
//   rqi_p                decoder ready
//   aki_n, cmd           delivery pulse and framed instruction {word0, word1}
//   flush_p, flush_adr   flush queue and redirect fetch
//
// state   | meaning
// ST_IDLE | no read outstanding; issue one when buffer has room
// ST_WAIT | read outstanding; mem_rq_p high until mem_ack
module prefetch_queue
    import pq_pkg::*;
#(
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rq_p,
    output logic [WORD_W-1:0] mem_adr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_din,
    input  logic              rqi_p,
    output logic              aki_n,
    output logic [CMD_W-1:0]  cmd,
    input  logic              flush_p,
    input  logic [WORD_W-1:0] flush_adr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic              drop;
    logic [WORD_W-1:0] fetch_pc;

    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic [CNT_W-1:0]  count;
    logic [1:0]        len;
    logic              valid;
    logic              load;
    logic              ack_take;
    logic              bypass;
    logic              push;
    logic [CMD_W-1:0]  cmd_load;

    assign len = instr_len(word0);
    // Written so an empty buffer never looks valid, even with unwritten entries.
    assign valid    = (count >= CNT_W'(2)) || ((count != '0) && (len == 2'd1));
    assign load     = rqi_p && valid && !aki_n && !flush_p;
    assign ack_take = (state == ST_WAIT) && mem_ack && !drop && !flush_p;
    assign cmd_load = {word0, (len == 2'd2) ? word1 : {WORD_W{1'b0}}};

`ifdef PQ_BYPASS_EN
    assign bypass = ack_take && (count == '0) && rqi_p && !aki_n &&
                    (instr_len(mem_din) == 2'd1);
`else
    assign bypass = 1'b0;
`endif

    assign push = ack_take && !bypass;

    pq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush_p),
        .push    (push),
        .din     (mem_din),
        .pop     (load),
        .pop_two (len == 2'd2),
        .word0   (word0),
        .word1   (word1),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            drop     <= 1'b0;
            fetch_pc <= RESET_PC;
            mem_rq_p <= 1'b0;
            mem_adr  <= RESET_PC;
            aki_n    <= 1'b0;
            cmd      <= '0;
        end else begin
            // load and bypass are both gated by !flush_p, so a flush forces aki_n low.
            aki_n <= load || bypass;
            if (load) begin
                cmd <= cmd_load;
            end else if (bypass) begin
                cmd <= {mem_din, {WORD_W{1'b0}}};
            end

            case (state)
                ST_IDLE: begin
                    if (flush_p) begin
                        fetch_pc <= flush_adr;
                    end else if (count < CNT_W'(DEPTH)) begin
                        mem_rq_p <= 1'b1;
                        mem_adr  <= fetch_pc;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_rq_p <= 1'b0;
                        state    <= ST_IDLE;
                        // A flush on the completing edge already discards this
                        // word, so the following read must not be dropped.
                        drop     <= 1'b0;
                        if (flush_p) begin
                            fetch_pc <= flush_adr;
                        end else if (!drop) begin
                            fetch_pc <= fetch_pc + 16'd1;
                        end
                    end else if (flush_p) begin
                        drop     <= 1'b1;
                        fetch_pc <= flush_adr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed self-checking bench for prefetch_queue.
// A memory responder answers reads one cycle after the request is seen and
// logs the addresses; a monitor logs every aki_n pulse with its cmd.
module tb_prefetch_queue;

`ifdef PQ_BYPASS_EN
    localparam int SHORT_LAT = 1;
`else
    localparam int SHORT_LAT = 2;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        mem_rq_p;
    logic [15:0] mem_adr;
    logic        mem_ack   = 1'b0;
    logic [15:0] mem_din   = 16'h0000;
    logic        rqi_p     = 1'b0;
    logic        aki_n;
    logic [31:0] cmd;
    logic        flush_p   = 1'b0;
    logic [15:0] flush_adr = 16'h0000;

    logic [15:0] mem_img [65536];
    logic        mem_en  = 1'b0;
    int          inj_req = 0;
    int          inj_done = 0;

    int          cyc = 0;
    int          n_reads = 0;
    logic [15:0] adr_log [4096];
    int          ack_cyc [4096];
    int          n_pulse = 0;
    int          n_consec = 0;
    logic [31:0] cmd_log [4096];
    int          pulse_cyc [4096];

    int errors = 0;
    int checks = 0;
    int rb = 0;
    int pb = 0;

    prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rq_p  (mem_rq_p),
        .mem_adr   (mem_adr),
        .mem_ack   (mem_ack),
        .mem_din   (mem_din),
        .rqi_p     (rqi_p),
        .aki_n     (aki_n),
        .cmd       (cmd),
        .flush_p   (flush_p),
        .flush_adr (flush_adr)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: one-cycle ack, at most one per request.
    initial forever begin
        @(negedge clk);
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (inj_req != inj_done) begin
            mem_ack  = 1'b1;
            mem_din  = 16'hF999;
            inj_done = inj_done + 1;
        end else if (mem_rq_p === 1'b1 && mem_en) begin
            mem_ack = 1'b1;
            mem_din = mem_img[mem_adr];
            if (n_reads < 4096) begin
                adr_log[n_reads] = mem_adr;
                ack_cyc[n_reads] = cyc;
            end
            n_reads = n_reads + 1;
        end
    end

    // Delivery monitor.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (aki_n === 1'b1) begin
                if (prev) n_consec = n_consec + 1;
                if (n_pulse < 4096) begin
                    cmd_log[n_pulse]   = cmd;
                    pulse_cyc[n_pulse] = cyc;
                end
                n_pulse = n_pulse + 1;
            end
            prev = (aki_n === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        flush_p = 1'b0;
        rqi_p   = 1'b0;
        mem_en  = 1'b0;
        rst     = 1'b1;
        tick(2);
        rst = 1'b0;
        rb  = n_reads;
        pb  = n_pulse;
    endtask

    task automatic wait_reads(input int target, input int lim);
        int k;
        k = 0;
        while (n_reads < target && k < lim) begin
            tick(1);
            k++;
        end
        checks++;
        if (n_reads < target) begin
            errors++;
            $display("FAIL wait_reads timeout: got %0d reads, want %0d", n_reads, target);
        end
    endtask

    task automatic wait_pulses(input int target, input int lim);
        int k;
        k = 0;
        while (n_pulse < target && k < lim) begin
            tick(1);
            k++;
        end
        checks++;
        if (n_pulse < target) begin
            errors++;
            $display("FAIL wait_pulses timeout: got %0d pulses, want %0d", n_pulse, target);
        end
    endtask

    task automatic test_reset();
        int k;
        #1 rst = 1'b1;
        #2;
        checks++; if (mem_rq_p !== 1'b0) begin errors++; $display("FAIL reset_rq: got %b want 0", mem_rq_p); end
        checks++; if (mem_adr !== 16'h0000) begin errors++; $display("FAIL reset_adr: got %h want 0000", mem_adr); end
        checks++; if (aki_n !== 1'b0) begin errors++; $display("FAIL reset_aki: got %b want 0", aki_n); end
        checks++; if (cmd !== 32'h0) begin errors++; $display("FAIL reset_cmd: got %h want 00000000", cmd); end
        for (int i = 0; i < 8; i++) mem_img[i] = 16'hC100 + 16'(i);
        tick(1);
        rst = 1'b0;
        rb = n_reads;
        pb = n_pulse;
        rqi_p  = 1'b1;
        mem_en = 1'b1;
        wait_reads(rb + 3, 40);
        wait_pulses(pb + 1, 40);
        mem_en = 1'b0;
        k = 0;
        while (mem_rq_p !== 1'b1 && k < 10) begin tick(1); k++; end
        checks++; if (mem_rq_p !== 1'b1) begin errors++; $display("FAIL reset_pending_rq: got %b want 1", mem_rq_p); end
        checks++; if (cmd_log[pb] !== 32'hC1000000) begin errors++; $display("FAIL reset_first_cmd: got %h want C1000000", cmd_log[pb]); end
        // asynchronous reset in the middle of an outstanding read
        rst = 1'b1;
        #1;
        checks++; if (mem_rq_p !== 1'b0) begin errors++; $display("FAIL midreset_rq: got %b want 0", mem_rq_p); end
        checks++; if (mem_adr !== 16'h0000) begin errors++; $display("FAIL midreset_adr: got %h want 0000", mem_adr); end
        checks++; if (aki_n !== 1'b0) begin errors++; $display("FAIL midreset_aki: got %b want 0", aki_n); end
        checks++; if (cmd !== 32'h0) begin errors++; $display("FAIL midreset_cmd: got %h want 00000000", cmd); end
        mem_img[0] = 16'hC777;
        tick(1);
        // late ack arrives in the first cycle after reset, with mem_rq_p low
        rst = 1'b0;
        inj_req = inj_req + 1;
        rb = n_reads;
        pb = n_pulse;
        tick(1);
        mem_en = 1'b1;
        wait_pulses(pb + 1, 40);
        checks++; if (cmd_log[pb] !== 32'hC7770000) begin errors++; $display("FAIL late_ack_cmd: got %h want C7770000", cmd_log[pb]); end
        checks++; if (adr_log[rb] !== 16'h0000) begin errors++; $display("FAIL late_ack_adr: got %h want 0000", adr_log[rb]); end
    endtask

    task automatic test_two_word();
        do_reset();
        mem_img[0] = 16'h1234;
        mem_img[1] = 16'h5678;
        for (int i = 2; i < 32; i++) mem_img[i] = 16'h0000;
        rqi_p  = 1'b1;
        mem_en = 1'b1;
        wait_reads(rb + 2, 20);
        checks++; if (n_pulse !== pb) begin errors++; $display("FAIL two_word_early: got %0d pulses want %0d", n_pulse - pb, 0); end
        wait_pulses(pb + 1, 20);
        checks++; if (adr_log[rb] !== 16'h0000) begin errors++; $display("FAIL two_word_adr0: got %h want 0000", adr_log[rb]); end
        checks++; if (adr_log[rb+1] !== 16'h0001) begin errors++; $display("FAIL two_word_adr1: got %h want 0001", adr_log[rb+1]); end
        checks++; if (cmd_log[pb] !== 32'h12345678) begin errors++; $display("FAIL two_word_cmd: got %h want 12345678", cmd_log[pb]); end
        checks++; if (pulse_cyc[pb] - ack_cyc[rb+1] !== 2) begin errors++; $display("FAIL two_word_lat: got %0d want 2", pulse_cyc[pb] - ack_cyc[rb+1]); end
    endtask

    task automatic test_one_word();
        do_reset();
        mem_img[0] = 16'hC123;
        mem_img[1] = 16'h1111;
        mem_img[2] = 16'h2222;
        for (int i = 3; i < 32; i++) mem_img[i] = 16'h0000;
        rqi_p  = 1'b1;
        mem_en = 1'b1;
        wait_pulses(pb + 2, 40);
        checks++; if (cmd_log[pb] !== 32'hC1230000) begin errors++; $display("FAIL one_word_cmd: got %h want C1230000", cmd_log[pb]); end
        checks++; if (cmd_log[pb+1] !== 32'h11112222) begin errors++; $display("FAIL one_word_next: got %h want 11112222", cmd_log[pb+1]); end
    endtask

    task automatic test_full();
        logic [15:0] w;
        int gap;
        do_reset();
        for (int i = 0; i < 32; i++) mem_img[i] = 16'hC000 + 16'(i);
        mem_en = 1'b1;
        tick(20);
        checks++; if (n_reads - rb !== 4) begin errors++; $display("FAIL full_reads: got %0d want 4", n_reads - rb); end
        checks++; if (mem_rq_p !== 1'b0) begin errors++; $display("FAIL full_rq: got %b want 0", mem_rq_p); end
        checks++; if (n_pulse !== pb) begin errors++; $display("FAIL full_nopulse: got %0d want %0d", n_pulse, pb); end
        rqi_p = 1'b1;
        wait_pulses(pb + 4, 40);
        for (int i = 0; i < 4; i++) begin
            w = 16'hC000 + 16'(i);
            checks++;
            if (cmd_log[pb+i] !== {w, 16'h0000}) begin
                errors++;
                $display("FAIL full_cmd%0d: got %h want %h", i, cmd_log[pb+i], {w, 16'h0000});
            end
        end
        for (int i = 0; i < 3; i++) begin
            gap = pulse_cyc[pb+i+1] - pulse_cyc[pb+i];
            checks++;
            if (gap !== 2) begin errors++; $display("FAIL full_gap%0d: got %0d want 2", i, gap); end
        end
        checks++; if (n_consec !== 0) begin errors++; $display("FAIL aki_consecutive: got %0d want 0", n_consec); end
    endtask

    task automatic test_flush_wait();
        int k;
        do_reset();
        mem_img[0] = 16'h1000;
        mem_img[1] = 16'h2000;
        mem_img[2] = 16'h3000;
        mem_img[3] = 16'hF333;
        mem_img[16'h0040] = 16'hC0AA;
        mem_img[16'h0041] = 16'hB0BB;
        mem_img[16'h0042] = 16'h0CCC;
        for (int i = 16'h43; i < 16'h60; i++) mem_img[i] = 16'h0000;
        mem_en = 1'b1;
        wait_reads(rb + 3, 30);
        mem_en = 1'b0;
        k = 0;
        while (mem_rq_p !== 1'b1 && k < 10) begin tick(1); k++; end
        checks++; if (mem_adr !== 16'h0003) begin errors++; $display("FAIL flush_pre_adr: got %h want 0003", mem_adr); end
        flush_adr = 16'h0040;
        flush_p   = 1'b1;
        tick(1);
        flush_p = 1'b0;
        rqi_p   = 1'b1;
        checks++; if (mem_rq_p !== 1'b1 || mem_adr !== 16'h0003) begin errors++; $display("FAIL flush_inflight: got rq=%b adr=%h want rq=1 adr=0003", mem_rq_p, mem_adr); end
        mem_en = 1'b1;
        wait_pulses(pb + 2, 40);
        checks++; if (adr_log[rb+3] !== 16'h0003) begin errors++; $display("FAIL flush_adr_old: got %h want 0003", adr_log[rb+3]); end
        checks++; if (adr_log[rb+4] !== 16'h0040) begin errors++; $display("FAIL flush_adr_new: got %h want 0040", adr_log[rb+4]); end
        checks++; if (cmd_log[pb] !== 32'hC0AA0000) begin errors++; $display("FAIL flush_cmd0: got %h want C0AA0000", cmd_log[pb]); end
        checks++; if (cmd_log[pb+1] !== 32'hB0BB0CCC) begin errors++; $display("FAIL flush_cmd1: got %h want B0BB0CCC", cmd_log[pb+1]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_cmd [5];
        exp_cmd[0] = 32'hC0000000;
        exp_cmd[1] = 32'hC0010000;
        exp_cmd[2] = 32'hC0020000;
        exp_cmd[3] = 32'h2AAA2BBB;
        exp_cmd[4] = 32'hE5550000;
        do_reset();
        mem_img[0] = 16'hC000;
        mem_img[1] = 16'hC001;
        mem_img[2] = 16'hC002;
        mem_img[3] = 16'h2AAA;
        mem_img[4] = 16'h2BBB;
        mem_img[5] = 16'hE555;
        for (int i = 6; i < 64; i++) mem_img[i] = 16'h0000;
        mem_img[16'hFFFF] = 16'h1ABC;
        rqi_p  = 1'b1;
        mem_en = 1'b1;
        wait_pulses(pb + 5, 60);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_log[pb+i] !== exp_cmd[i]) begin
                errors++;
                $display("FAIL wrap_cmd%0d: got %h want %h", i, cmd_log[pb+i], exp_cmd[i]);
            end
        end
        rqi_p = 1'b0;
        tick(20);
        rb = n_reads;
        pb = n_pulse;
        flush_adr = 16'hFFFF;
        flush_p   = 1'b1;
        tick(1);
        flush_p = 1'b0;
        rqi_p   = 1'b1;
        wait_pulses(pb + 1, 40);
        checks++; if (adr_log[rb] !== 16'hFFFF) begin errors++; $display("FAIL pc_wrap_adr0: got %h want FFFF", adr_log[rb]); end
        checks++; if (adr_log[rb+1] !== 16'h0000) begin errors++; $display("FAIL pc_wrap_adr1: got %h want 0000", adr_log[rb+1]); end
        checks++; if (cmd_log[pb] !== 32'h1ABCC000) begin errors++; $display("FAIL pc_wrap_cmd: got %h want 1ABCC000", cmd_log[pb]); end
    endtask

    task automatic test_latency();
        int lat;
        do_reset();
        mem_img[0] = 16'hD001;
        for (int i = 1; i < 32; i++) mem_img[i] = 16'h0000;
        rqi_p  = 1'b1;
        mem_en = 1'b1;
        wait_pulses(pb + 1, 30);
        lat = pulse_cyc[pb] - ack_cyc[rb];
        checks++; if (cmd_log[pb] !== 32'hD0010000) begin errors++; $display("FAIL latency_cmd: got %h want D0010000", cmd_log[pb]); end
        checks++; if (lat !== SHORT_LAT) begin errors++; $display("FAIL latency_cycles: got %0d want %0d", lat, SHORT_LAT); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_img[i] = 16'h0000;
        test_reset();
        test_two_word();
        test_one_word();
        test_full();
        test_flush_wait();
        test_wrap();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
